uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver and successor to the fixed 8N2 receiver. Adds configurable data width, oversampling ratio and stop-bit count, plus optional even/odd parity. Also adds an input synchroniser, false-start rejection, error reporting, and a valid/ready output handshake with overrun detection. It sits between the pad-side rx line and the byte consumer (FIFO/ALU interface) and is driven by the shared baud-tick generator.

Parameters:
NB_DATA, 8, data bits per frame (5..9), LSB first
NB_STOP, 1, stop bits (1 or 2)
OVERSAMPLE, 16, i_tick pulses per bit period (even, 8..32)
PARITY_EN, 0, 1 = parity bit present after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_tick  in  1  one-cycle baud-oversample strobe
i_rx  in  1  raw serial line, idle high, asynchronous to i_clk
i_ready  in  1  consumer accepts o_data when o_valid&i_ready
o_data  out  NB_DATA  received word, bit 0 = first received bit
o_valid  out  1  word available; held until accepted
o_parity_err  out  1  parity mismatch for word on o_data
o_frame_err  out  1  a stop bit sampled low for word on o_data
o_overrun  out  1  word on o_data overwrote an unaccepted word

Behaviour:
- Reset (async assert, sync deassert via the reset tree): state IDLE, all counters 0, o_data 0, o_valid 0, all error outputs 0, synchroniser flops 1.
- i_rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, so line-to-decision latency is 2 cycles.
- Tick counter width $clog2(OVERSAMPLE). Bit counter width $clog2(NB_DATA+1). The counter advances only on i_tick.
- IDLE: rx_s==0 -> START with tick cnt=0. Ticks are ignored while IDLE.
- START: on tick with cnt==OVERSAMPLE/2-1 (mid start bit):
  - rx_s==1 -> IDLE (glitch rejected, nothing reported).
  - rx_s==0 -> DATA, cnt=0, n_bit=0.
- DATA: on tick with cnt==OVERSAMPLE-1, shift data = {rx_s, data[NB_DATA-1:1]}, cnt=0, and fold rx_s into the running XOR.
  - After bit NB_DATA-1 -> PARITY if PARITY_EN, else STOP.
- PARITY: sample at mid-bit, cnt=0 -> STOP. par_err = (xor_data ^ rx_s ^ PARITY_ODD) != 0.
- STOP: sample at each mid-bit. Any low sample sets frm_err. Completion occurs at the mid-point of the last stop bit; FSM returns to IDLE on that same tick, which allows back-to-back frames.
- Completion cycle (registered, 1 cycle after the final sampling tick):
  - o_data <= shift reg; o_parity_err <= par_err; o_frame_err <= frm_err; o_valid <= 1.
  - o_overrun <= o_valid & ~i_ready, i.e. the previous word was still unaccepted.
- Handshake: o_valid&i_ready with no completion in that cycle -> o_valid <= 0. The error flags and o_overrun clear with it. o_data holds its last value.
- Simultaneous completion and acceptance: new word loads, o_valid stays 1, o_overrun=0.
- A frame with errors is still delivered with o_valid. The consumer decides whether to discard it.
- Line held low (break) gives a frame_err word, then the FSM waits in IDLE. A new start is recognised only after rx_s returns high and then falls; a break flag tracks this.
- An unknown state encoding -> IDLE.
- Reset mid-frame aborts the frame and outputs no word.

Decomposition:
- Shared package uart_pkg:
  - One-hot state localparams (IDLE, START, DATA, PARITY, STOP).
  - Parity mode constants.
  - Helper function for counter widths.
  - These are shared with the planned uart_tx_cfg.
- Sub-module uart_sync2 (2-flop synchroniser, parametrised reset value) is natural and reused by the transmitter's CTS input.

Test Plan:
- Defaults (8N1, OVERSAMPLE=16, tick every 4 cycles): send 0xA5, i_ready=1 -> o_data=0xA5, o_valid high exactly 1 cycle, no error flags.
- 2-cycle low glitch on i_rx (shorter than half a bit) -> FSM returns to IDLE; o_valid never asserts.
- PARITY_EN=1, PARITY_ODD=0, send 0x3C with parity bit 1 (wrong) -> o_data=0x3C, o_parity_err=1. Repeat with parity bit 0 -> o_parity_err=0.
- NB_STOP=2, send 0x55 with second stop bit driven low -> o_frame_err=1 and o_valid=1. The following frame 0x0F, sent correctly, is received clean.
- i_ready=0, send 0x11 then 0x22 back-to-back -> after the second completion o_data=0x22, o_overrun=1. Raising i_ready clears o_valid and o_overrun next cycle.
- NB_DATA=7, OVERSAMPLE=8: send 0x7F, then assert i_reset_n=0 halfway through frame 0x01 -> first word 0x7F valid; after reset all outputs are 0 and no word appears for the aborted frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the configurable UART receiver and transmitter.
//   - one-hot FSM state encodings
//   - parity mode constants
//   - cnt_width(): counter width for a counter that must hold values 0..n-1
package uart_pkg;

  localparam int ST_W = 5;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE   = 5'b00001;
  localparam state_t ST_START  = 5'b00010;
  localparam state_t ST_DATA   = 5'b00100;
  localparam state_t ST_PARITY = 5'b01000;
  localparam state_t ST_STOP   = 5'b10000;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Never narrower than one bit, so tiny ranges still give a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: groups the receiver's line, tick and consumer-side signals.
//   tick                 baud-oversample strobe
//   rx                   raw serial line (idle high)
//   ready                consumer ready
//   data/valid           received word and its valid flag
//   parity_err/frame_err error flags qualifying data
//   overrun              data replaced a word that was never accepted
// Handshake: a word transfers on every cycle where valid and ready are both
// high. valid stays high, with data and flags stable, until that transfer,
// unless a newer word replaces it (then overrun is raised with the new word).
interface uart_rx_cfg_if #(
  parameter int NB_DATA = 8
);
  logic               tick;
  logic               rx;
  logic               ready;
  logic [NB_DATA-1:0] data;
  logic               valid;
  logic               parity_err;
  logic               frame_err;
  logic               overrun;

  modport master (
    output tick, rx, ready,
    input  data, valid, parity_err, frame_err, overrun
  );

  modport slave (
    input  tick, rx, ready,
    output data, valid, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for a single asynchronous input.
//   clk    destination clock
//   rst_n  asynchronous active-low reset, both flops load RST_VAL
//   d      asynchronous input
//   q      synchronised output (2-cycle latency)
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with valid/ready output.
//   i_clk, i_reset_n   clock and asynchronous active-low reset
//   i_tick             one-cycle strobe, OVERSAMPLE per bit period
//   i_rx               raw serial line, idle high, asynchronous
//   i_ready            consumer accepts o_data when o_valid & i_ready
//   o_data             received word, bit 0 = first received bit
//   o_valid            word available, held until accepted
//   o_parity_err       parity mismatch for the word on o_data
//   o_frame_err        a stop bit was sampled low for the word on o_data
//   o_overrun          the word on o_data replaced an unaccepted word
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int NB_STOP    = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_tick,
  input  logic               i_rx,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_overrun
);

  localparam int TW = cnt_width(OVERSAMPLE);
  localparam int BW = cnt_width(NB_DATA + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NB_DATA - 1);
  localparam logic [BW-1:0] S_LAST = BW'(NB_STOP - 1);
  localparam logic PAR_BIT = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic               rx_s;
  state_t             state_q, state_d;
  logic [TW-1:0]      tick_q;
  logic [BW-1:0]      bit_q;
  logic [NB_DATA-1:0] shift_q;
  logic               xor_q, perr_q, ferr_q, brk_q, done_q;

  // Per-cycle strobes decoded from state and inputs.
  logic tick_clr, tick_inc, bit_clr, bit_inc;
  logic frame_start, data_smp, par_smp, stop_smp, frame_done;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .d     (i_rx),
    .q     (rx_s)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic. After START the counter is realigned to mid-bit, so every
  // later sample point is a full bit period (T_FULL) after the previous one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!rx_s && !brk_q) state_d = ST_START;
      ST_START:  if (i_tick && tick_q == T_MID) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (i_tick && tick_q == T_FULL && bit_q == B_LAST)
                   state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (i_tick && tick_q == T_FULL) state_d = ST_STOP;
      ST_STOP:   if (i_tick && tick_q == T_FULL && bit_q == S_LAST) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output (strobe) decode.
  always_comb begin
    tick_clr    = 1'b0;
    tick_inc    = 1'b0;
    bit_clr     = 1'b0;
    bit_inc     = 1'b0;
    frame_start = 1'b0;
    data_smp    = 1'b0;
    par_smp     = 1'b0;
    stop_smp    = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s && !brk_q) begin
          tick_clr    = 1'b1;
          frame_start = 1'b1;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (tick_q == T_MID) begin
            tick_clr = 1'b1;
            bit_clr  = 1'b1;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (tick_q == T_FULL) begin
            tick_clr = 1'b1;
            data_smp = 1'b1;
            if (bit_q == B_LAST) bit_clr = 1'b1;
            else                 bit_inc = 1'b1;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (i_tick) begin
          if (tick_q == T_FULL) begin
            tick_clr = 1'b1;
            bit_clr  = 1'b1;
            par_smp  = 1'b1;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (i_tick) begin
          if (tick_q == T_FULL) begin
            tick_clr = 1'b1;
            stop_smp = 1'b1;
            if (bit_q == S_LAST) frame_done = 1'b1;
            else                 bit_inc    = 1'b1;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Counters, shift register and per-frame error accumulation.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      xor_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (tick_clr)      tick_q <= '0;
      else if (tick_inc) tick_q <= tick_q + TW'(1);
      if (bit_clr)       bit_q  <= '0;
      else if (bit_inc)  bit_q  <= bit_q + BW'(1);
      if (frame_start) begin
        xor_q  <= 1'b0;
        perr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (data_smp) begin
        shift_q <= {rx_s, shift_q[NB_DATA-1:1]};
        xor_q   <= xor_q ^ rx_s;
      end
      if (par_smp)            perr_q <= xor_q ^ rx_s ^ PAR_BIT;
      if (stop_smp && !rx_s)  ferr_q <= 1'b1;
      // A frame ending on a low line is a break: block new starts until the
      // line has been seen high again.
      if (frame_done && !rx_s) brk_q <= 1'b1;
      else if (rx_s)           brk_q <= 1'b0;
      done_q <= frame_done;
    end
  end

  // Consumer-side output register; a new word has priority over acceptance.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (done_q) begin
      o_data       <= shift_q;
      o_parity_err <= perr_q;
      o_frame_err  <= ferr_q;
      o_valid      <= 1'b1;
      o_overrun    <= o_valid & ~i_ready;
    end else if (o_valid && i_ready) begin
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: bench for uart_rx_cfg. Three instances cover
//   a: 8N1, OVERSAMPLE 16    b: 8E2, OVERSAMPLE 16    c: 7N1, OVERSAMPLE 8
// Expected words come from a frame-level model (data, parity rule, stop bits).
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       tick;
  logic [2:0] rst_n, rx, ready;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [11:0] exp_q0[$];
  logic [11:0] exp_q1[$];
  logic [11:0] exp_q2[$];

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.NB_DATA(8)) bus_a ();
  uart_rx_cfg_if #(.NB_DATA(8)) bus_b ();
  uart_rx_cfg_if #(.NB_DATA(7)) bus_c ();

  assign bus_a.tick = tick;  assign bus_a.rx = rx[0];  assign bus_a.ready = ready[0];
  assign bus_b.tick = tick;  assign bus_b.rx = rx[1];  assign bus_b.ready = ready[1];
  assign bus_c.tick = tick;  assign bus_c.rx = rx[2];  assign bus_c.ready = ready[2];

  uart_rx_cfg #(.NB_DATA(8), .NB_STOP(1), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n[0]), .i_tick(bus_a.tick), .i_rx(bus_a.rx),
    .i_ready(bus_a.ready), .o_data(bus_a.data), .o_valid(bus_a.valid),
    .o_parity_err(bus_a.parity_err), .o_frame_err(bus_a.frame_err), .o_overrun(bus_a.overrun)
  );

  uart_rx_cfg #(.NB_DATA(8), .NB_STOP(2), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n[1]), .i_tick(bus_b.tick), .i_rx(bus_b.rx),
    .i_ready(bus_b.ready), .o_data(bus_b.data), .o_valid(bus_b.valid),
    .o_parity_err(bus_b.parity_err), .o_frame_err(bus_b.frame_err), .o_overrun(bus_b.overrun)
  );

  uart_rx_cfg #(.NB_DATA(7), .NB_STOP(1), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_c (
    .i_clk(clk), .i_reset_n(rst_n[2]), .i_tick(bus_c.tick), .i_rx(bus_c.rx),
    .i_ready(bus_c.ready), .o_data(bus_c.data), .o_valid(bus_c.valid),
    .o_parity_err(bus_c.parity_err), .o_frame_err(bus_c.frame_err), .o_overrun(bus_c.overrun)
  );

  logic [8:0] dat[3];
  logic [2:0] vld, per, fer, ovr;
  assign dat[0] = {1'b0, bus_a.data};
  assign dat[1] = {1'b0, bus_b.data};
  assign dat[2] = {2'b00, bus_c.data};
  assign vld = {bus_c.valid, bus_b.valid, bus_a.valid};
  assign per = {bus_c.parity_err, bus_b.parity_err, bus_a.parity_err};
  assign fer = {bus_c.frame_err, bus_b.frame_err, bus_a.frame_err};
  assign ovr = {bus_c.overrun, bus_b.overrun, bus_a.overrun};

  // Instance configuration as seen by the bench.
  function automatic int os_of(input int k);    return (k == 2) ? 8 : 16; endfunction
  function automatic int nb_of(input int k);    return (k == 2) ? 7 : 8;  endfunction
  function automatic int nstop_of(input int k); return (k == 1) ? 2 : 1;  endfunction
  function automatic bit par_of(input int k);   return (k == 1);          endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: {overrun, frame_err, parity_err, data[8:0]}.
  function automatic logic [11:0] ref_word(input int k, input logic [8:0] word, input logic pbit,
                                           input logic [1:0] stops, input logic ovr_exp);
    logic [8:0] d;
    logic       pe, fe;
    d  = word & 9'((1 << nb_of(k)) - 1);
    // Even parity: data ones plus the parity bit must be even.
    pe = par_of(k) ? 1'(($countones(d) + int'(pbit)) % 2) : 1'b0;
    fe = (stops[0] == 1'b0) || (nstop_of(k) == 2 && stops[1] == 1'b0);
    return {ovr_exp, fe, pe, d};
  endfunction

  task automatic push_exp(input int k, input logic [11:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int k, output logic [11:0] v, output bit ok);
    ok = 1'b0;
    v  = '0;
    case (k)
      0: if (exp_q0.size() > 0) begin v = exp_q0.pop_front(); ok = 1'b1; end
      1: if (exp_q1.size() > 0) begin v = exp_q1.pop_front(); ok = 1'b1; end
      default: if (exp_q2.size() > 0) begin v = exp_q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Baud-oversample tick every 4 clocks.
  initial begin
    int c;
    c    = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (c == 3);
      c    = (c + 1) % 4;
    end
  end

  // Scoreboard: every accepted word must match the head of that instance's queue.
  int vcnt[3];
  initial for (int k = 0; k < 3; k++) vcnt[k] = 0;

  always @(negedge clk) begin
    logic [11:0] e;
    bit          ok;
    for (int k = 0; k < 3; k++) begin
      if (vld[k]) vcnt[k]++;
      if (vld[k] && ready[k]) begin
        pop_exp(k, e, ok);
        if (!ok) begin
          check_eq($sformatf("k%0d_unexpected_word", k), 32'd1, 32'd0);
        end else begin
          check_eq($sformatf("k%0d_data", k), 32'(dat[k]), 32'(e[8:0]));
          check_eq($sformatf("k%0d_parity_err", k), 32'(per[k]), 32'(e[9]));
          check_eq($sformatf("k%0d_frame_err", k), 32'(fer[k]), 32'(e[10]));
          check_eq($sformatf("k%0d_overrun", k), 32'(ovr[k]), 32'(e[11]));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int k, input logic v, input int n);
    rx[k] = v;
    idle(n);
  endtask

  task automatic send_frame(input int k, input logic [8:0] word, input logic pbit,
                            input logic [1:0] stops);
    int bc;
    bc = os_of(k) * 4;
    drive_bit(k, 1'b0, bc);
    for (int i = 0; i < nb_of(k); i++) drive_bit(k, word[i], bc);
    if (par_of(k)) drive_bit(k, pbit, bc);
    for (int s = 0; s < nstop_of(k); s++) drive_bit(k, stops[s], bc);
    rx[k] = 1'b1;
  endtask

  task automatic send_and_expect(input int k, input logic [8:0] word, input logic pbit,
                                 input logic [1:0] stops);
    push_exp(k, ref_word(k, word, pbit, stops, 1'b0));
    send_frame(k, word, pbit, stops);
  endtask

  initial begin
    int          base;
    int          k;
    logic [8:0]  w;
    logic        pb;
    logic [1:0]  st;

    rst_n = 3'b000;
    rx    = 3'b111;
    ready = 3'b111;
    idle(5);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("k%0d_reset_valid", i), 32'(vld[i]), 32'd0);
      check_eq($sformatf("k%0d_reset_data", i), 32'(dat[i]), 32'd0);
      check_eq($sformatf("k%0d_reset_flags", i), 32'({per[i], fer[i], ovr[i]}), 32'd0);
    end
    rst_n = 3'b111;
    idle(10);

    // Plain 8N1 word, valid must be a single-cycle pulse with ready high.
    base = vcnt[0];
    send_and_expect(0, 9'h0A5, 1'b0, 2'b11);
    idle(40);
    check_eq("a5_valid_cycles", 32'(vcnt[0] - base), 32'd1);
    check_eq("a5_data_held", 32'(dat[0]), 32'h0A5);

    // Short low glitch must be rejected.
    base = vcnt[0];
    rx[0] = 1'b0;
    idle(2);
    rx[0] = 1'b1;
    idle(200);
    check_eq("glitch_no_word", 32'(vcnt[0] - base), 32'd0);

    // Even parity: 0x3C has four ones, so parity bit 1 is wrong and 0 is right.
    send_and_expect(1, 9'h03C, 1'b1, 2'b11);
    idle(20);
    send_and_expect(1, 9'h03C, 1'b0, 2'b11);
    idle(20);

    // Second stop bit low, then a clean frame.
    send_and_expect(1, 9'h055, 1'b0, 2'b01);
    idle(20);
    send_and_expect(1, 9'h00F, 1'b0, 2'b11);
    idle(20);

    // Overrun: consumer stalled across two back-to-back frames.
    ready[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11);
    push_exp(0, ref_word(0, 9'h022, 1'b0, 2'b11, 1'b1));
    send_frame(0, 9'h022, 1'b0, 2'b11);
    idle(8);
    check_eq("ovr_valid", 32'(vld[0]), 32'd1);
    check_eq("ovr_data", 32'(dat[0]), 32'h022);
    check_eq("ovr_flag", 32'(ovr[0]), 32'd1);
    ready[0] = 1'b1;
    idle(2);
    check_eq("ovr_valid_cleared", 32'(vld[0]), 32'd0);
    check_eq("ovr_flag_cleared", 32'(ovr[0]), 32'd0);

    // 7-bit, OVERSAMPLE 8: one good word, then reset halfway through the next.
    send_and_expect(2, 9'h07F, 1'b0, 2'b11);
    idle(20);
    check_eq("c_data_7f", 32'(dat[2]), 32'h07F);
    drive_bit(2, 1'b0, 32);
    for (int i = 0; i < 4; i++) drive_bit(2, (i == 0), 32);
    rst_n[2] = 1'b0;
    rx[2]    = 1'b1;
    idle(3);
    check_eq("c_rst_data", 32'(dat[2]), 32'd0);
    check_eq("c_rst_valid", 32'(vld[2]), 32'd0);
    check_eq("c_rst_flags", 32'({per[2], fer[2], ovr[2]}), 32'd0);
    rst_n[2] = 1'b1;
    base = vcnt[2];
    idle(200);
    check_eq("c_aborted_no_word", 32'(vcnt[2] - base), 32'd0);
    check_eq("c_aborted_data", 32'(dat[2]), 32'd0);
    send_and_expect(2, 9'h02A, 1'b0, 2'b11);
    idle(20);

    // Randomised frames across all instances, occasionally with bad stop bits.
    for (int r = 0; r < 30; r++) begin
      k  = $urandom_range(0, 2);
      w  = 9'($urandom_range(0, 511));
      pb = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_and_expect(k, w, pb, st);
      idle($urandom_range(4, 30));
    end
    idle(100);

    check_eq("q0_drained", 32'(exp_q0.size()), 32'd0);
    check_eq("q1_drained", 32'(exp_q1.size()), 32'd0);
    check_eq("q2_drained", 32'(exp_q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
